btn_debounce: RTL



---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_debounce_chan.sv | 136 +++++++++++++
 rtl/btn_debounce.sv | 62 ++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: channel count, repeat phases, counter sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package btn_pkg;

    localparam int NUM_BTN = 8;

    // Auto-repeat phase of one channel: released, waiting for first repeat, repeating.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } rep_phase_t;

    // Counter width able to hold 0..limit (one spare bit keeps the compare simple).
    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchronizer, tick-based debounce, auto-repeat FSM.
// Latency: state/press/release 3..2+TICK_DIV cycles past the DEB_TICKS-th mismatching tick window; all outputs registered.
// Backpressure: none; pulses are single-cycle and never stall.
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int DEB_TICKS    = 8,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_state,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int DW = cnt_width(DEB_TICKS);
    localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [DW-1:0] DEB_LIM  = DW'(DEB_TICKS);
    localparam logic [RW-1:0] DLY_LIM  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RATE_LIM = RW'(REPEAT_RATE);

    logic            r_s1;
    logic            r_s2;
    logic            r_state;
    logic            r_press;
    logic            r_release;
    logic            r_repeat;
    logic [DW-1:0]   r_dcnt;
    logic [RW-1:0]   r_rcnt;
    rep_phase_t      r_phase;

    logic            w_state_n;
    logic            w_press_n;
    logic            w_release_n;
    logic [DW-1:0]   w_dcnt_n;
    logic [DW-1:0]   w_dcnt_inc;
    logic            w_repeat_n;
    logic [RW-1:0]   w_rcnt_n;
    logic [RW-1:0]   w_rcnt_inc;
    logic [RW-1:0]   w_rep_lim;
    rep_phase_t      w_phase_n;

    assign w_dcnt_inc = r_dcnt + DW'(1);
    assign w_rcnt_inc = r_rcnt + RW'(1);
    assign w_rep_lim  = (r_phase == RUN) ? RATE_LIM : DLY_LIM;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Debounce: count ticks of disagreement, any agreement restarts the count.
    always_comb begin
        w_state_n   = r_state;
        w_dcnt_n    = r_dcnt;
        w_press_n   = 1'b0;
        w_release_n = 1'b0;
        if (r_s2 == r_state) begin
            w_dcnt_n = '0;
        end else if (i_tick) begin
            if (w_dcnt_inc == DEB_LIM) begin
                w_state_n   = ~r_state;
                w_dcnt_n    = '0;
                w_press_n   = ~r_state;
                w_release_n = r_state;
            end else begin
                w_dcnt_n = w_dcnt_inc;
            end
        end
    end

    // Repeat FSM next state; a release accepted this cycle wins over a due repeat.
    always_comb begin
        w_phase_n  = r_phase;
        w_rcnt_n   = r_rcnt;
        w_repeat_n = 1'b0;
        if (!r_state || !w_state_n) begin
            w_phase_n = IDLE;
            w_rcnt_n  = '0;
        end else begin
            case (r_phase)
                IDLE:    w_phase_n = FIRST;
                FIRST:   w_phase_n = FIRST;
                RUN:     w_phase_n = RUN;
                default: w_phase_n = IDLE;
            endcase
            if (i_tick) begin
                if (w_rcnt_inc == w_rep_lim) begin
                    w_repeat_n = 1'b1;
                    w_rcnt_n   = '0;
                    w_phase_n  = RUN;
                end else begin
                    w_rcnt_n = w_rcnt_inc;
                end
            end
        end
    end

    // Debounced level, event pulses and counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            r_dcnt    <= '0;
            r_rcnt    <= '0;
            r_phase   <= IDLE;
        end else begin
            r_state   <= w_state_n;
            r_press   <= w_press_n;
            r_release <= w_release_n;
            r_repeat  <= w_repeat_n;
            r_dcnt    <= w_dcnt_n;
            r_rcnt    <= w_rcnt_n;
            r_phase   <= w_phase_n;
        end
    end

    assign o_state   = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;

endmodule

// File: rtl/btn_debounce.sv
// Eight-button input conditioner: polarity fix, shared tick prescaler, per-button debounce/repeat channels.
// Latency: accept (DEB_TICKS-1)*TICK_DIV+3 .. DEB_TICKS*TICK_DIV+2 cycles after a stable pin change; outputs registered.
// Backpressure: none; consumers must sample single-cycle pulses as they occur.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int TICK_DIV     = 48000,
    parameter int DEB_TICKS    = 8,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic [NUM_BTN-1:0] o_state,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_repeat
);

    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PLIM = PW'(TICK_DIV - 1);
    localparam logic          INV  = (ACTIVE_LOW != 0);

    logic [PW-1:0]      r_pcnt;
    logic               w_tick;
    logic [NUM_BTN-1:0] w_raw;

    // Normalise so that 1 always means pressed.
    assign w_raw  = i_btn ^ {NUM_BTN{INV}};
    assign w_tick = (r_pcnt == PLIM);

    // Free-running prescaler shared by all channels; wraps on the tick cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        btn_debounce_chan #(
            .DEB_TICKS    (DEB_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_tick    (w_tick),
            .i_raw     (w_raw[g]),
            .o_state   (o_state[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_repeat  (o_repeat[g])
        );
    end

endmodule
